// File: rtl/bsg_rr_arb_2_to_1_width_p32_if.sv
// rtl/bsg_rr_arb_2_to_1_width_p32_if.sv - handshake bundle between two requesters, the arbiter and the downstream sink
interface bsg_rr_arb_2_to_1_width_p32_if #(
  parameter int width_p = 32
);
  logic [1:0]           v_i;
  logic [2*width_p-1:0] data_i;
  logic [1:0]           ready_o;
  logic [1:0]           sel_one_hot_o;
  logic                 v_o;
  logic [width_p-1:0]   data_o;
  logic                 tag_o;
  logic                 ready_i;

  // Arbiter side
  modport slave (
    input  v_i,
    input  data_i,
    input  ready_i,
    output ready_o,
    output sel_one_hot_o,
    output v_o,
    output data_o,
    output tag_o
  );

  // Requester / sink side
  modport master (
    output v_i,
    output data_i,
    output ready_i,
    input  ready_o,
    input  sel_one_hot_o,
    input  v_o,
    input  data_o,
    input  tag_o
  );
endinterface

// File: rtl/bsg_rr_arb_2_to_1_width_p32.sv
// rtl/bsg_rr_arb_2_to_1_width_p32.sv - 2:1 round-robin arbiter with one registered output stage
// Grant is combinational from v_i and last_r only; data_i never reaches a control output.
module bsg_rr_arb_2_to_1_width_p32 #(
  parameter int width_p = 32
) (
  input logic                            clk_i,
  input logic                            reset_n_i,
  bsg_rr_arb_2_to_1_width_p32_if.slave   bus
);

  logic               v_r;
  logic [width_p-1:0] data_r;
  logic               tag_r;
  logic               last_r;

  logic [1:0]         grant;
  logic               enq_ok;
  logic               enq;
  logic [width_p-1:0] data_sel;

  always_comb begin
    grant = 2'b00;
    unique case (bus.v_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_r ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // The register refills in the same cycle it drains, so throughput is one word per cycle.
  assign enq_ok = ~v_r | bus.ready_i;
  assign enq    = (|grant) & enq_ok;

  assign data_sel = (bus.data_i[0*width_p +: width_p] & {width_p{grant[0]}})
                  | (bus.data_i[1*width_p +: width_p] & {width_p{grant[1]}});

  // Reset gating keeps requesters from seeing an accept while the stage is held in reset.
  assign bus.ready_o       = grant & {2{enq_ok & reset_n_i}};
  assign bus.sel_one_hot_o = grant;
  assign bus.v_o           = v_r;
  assign bus.data_o        = data_r;
  assign bus.tag_o         = tag_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_r    <= 1'b0;
      data_r <= '0;
      tag_r  <= 1'b0;
      last_r <= 1'b1;
    end else if (enq) begin
      v_r    <= 1'b1;
      data_r <= data_sel;
      tag_r  <= grant[1];
      last_r <= grant[1];
    end else if (v_r && bus.ready_i) begin
      v_r    <= 1'b0;
    end
  end

endmodule
